// File: rtl/sp_usb_fifo_dev.sv
// sp_usb_fifo_dev
//   Device-side model of an 8-bit synchronous USB FIFO chip. It is the
//   counterpart of the FPGA-side USB controller. Host-side byte streams fill
//   an RX FIFO (host->FPGA) that the FPGA reads with rd_n. The FPGA writes a
//   TX FIFO (FPGA->host) with wr_n, and the host drains it. It runs on the
//   same clk as the controller under test.
//
// Parameters
//   DEPTH_LOG2  log2 of RX/TX FIFO depth
//   RD_LATENCY  clocks from the sampled rd_n fall until usb_data is valid (1..7)
//   RECOVER     clocks rxf_n/txe_n are held high after rd_n/wr_n rise (1..7)
//
// Ports
//   clk         clock; all logic updates on the rising edge
//   rst         asynchronous reset, active low
//   usb_data    shared data bus; this model drives it only during a read
//   rxf_n       low = an RX byte is available to the FPGA
//   txe_n       low = the TX FIFO can accept a byte
//   rd_n, wr_n  read/write strobes from the FPGA, active low
//   host_din    host byte to push into the RX FIFO
//   host_write  push request for host_din (ignored while host_full)
//   host_full   RX FIFO full
//   host_dout   TX FIFO head byte
//   host_read   pop request for the TX head (ignored while !host_avail)
//   host_avail  TX FIFO non-empty
//   rx_count    RX FIFO occupancy
//   tx_count    TX FIFO occupancy
//   err         sticky flags: [0] = read strobe while rxf_n high,
//               [1] = wr_n low while this model drives the bus
module sp_usb_fifo_dev #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned RECOVER    = 3
) (
    input  logic                clk,
    input  logic                rst,
    inout  wire  [7:0]          usb_data,
    output logic                rxf_n,
    output logic                txe_n,
    input  logic                rd_n,
    input  logic                wr_n,
    input  logic [7:0]          host_din,
    input  logic                host_write,
    output logic                host_full,
    output logic [7:0]          host_dout,
    input  logic                host_read,
    output logic                host_avail,
    output logic [DEPTH_LOG2:0] rx_count,
    output logic [DEPTH_LOG2:0] tx_count,
    output logic [1:0]          err
);

    localparam int unsigned       DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL   = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [2:0]        LAT_INIT = 3'(RD_LATENCY - 1);
    localparam logic [2:0]        REC_INIT = 3'(RECOVER - 1);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DRIVE, R_RECOVER} rx_state_t;
    typedef enum logic       {T_IDLE, T_RECOVER}                  tx_state_t;

    rx_state_t             rx_state, rx_state_d;
    tx_state_t             tx_state, tx_state_d;
    logic [2:0]            rx_cnt, rx_cnt_d, tx_cnt, tx_cnt_d;
    logic                  rd_q, wr_q;
    logic                  rd_fall, rd_rise, wr_rise;
    logic [7:0]            data_q;
    logic [7:0]            rx_mem [DEPTH];
    logic [7:0]            tx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rx_wr_ptr, rx_rd_ptr, tx_wr_ptr, tx_rd_ptr;
    logic [DEPTH_LOG2:0]   rx_count_d, tx_count_d;
    logic                  rx_push, rx_pop, tx_push, tx_pop;
    logic                  drive;

    assign rd_fall = rd_q & ~rd_n;
    assign rd_rise = ~rd_q & rd_n;
    assign wr_rise = ~wr_q & wr_n;

    // The bus enable is a decode of the state register, so an async reset
    // releases the bus immediately.
    assign drive     = (rx_state == R_DRIVE);
    assign usb_data  = drive ? rx_mem[rx_rd_ptr] : 'z;
    assign host_dout = tx_mem[tx_rd_ptr];

    assign rx_push = host_write & ~host_full;
    assign rx_pop  = rd_rise & ((rx_state == R_WAIT) || (rx_state == R_DRIVE)) & (rx_count != '0);
    assign tx_push = wr_rise & (tx_count != FULL);
    assign tx_pop  = host_read & host_avail;

    always_comb begin
        rx_count_d = rx_count;
        if (rx_push && !rx_pop)
            rx_count_d = rx_count + ONE;
        else if (!rx_push && rx_pop)
            rx_count_d = rx_count - ONE;
        tx_count_d = tx_count;
        if (tx_push && !tx_pop)
            tx_count_d = tx_count + ONE;
        else if (!tx_push && tx_pop)
            tx_count_d = tx_count - ONE;
    end

    always_comb begin
        rx_state_d = rx_state;
        rx_cnt_d   = rx_cnt;
        case (rx_state)
            R_IDLE: begin
                if (rd_fall && !rxf_n) begin
                    rx_state_d = R_WAIT;
                    rx_cnt_d   = LAT_INIT;
                end
            end
            R_WAIT: begin
                if (rd_rise) begin
                    rx_state_d = R_RECOVER;
                    rx_cnt_d   = REC_INIT;
                end else if (rx_cnt == '0) begin
                    rx_state_d = R_DRIVE;
                end else begin
                    rx_cnt_d = rx_cnt - 3'd1;
                end
            end
            R_DRIVE: begin
                if (rd_rise) begin
                    rx_state_d = R_RECOVER;
                    rx_cnt_d   = REC_INIT;
                end
            end
            R_RECOVER: begin
                if (rx_cnt == '0)
                    rx_state_d = R_IDLE;
                else
                    rx_cnt_d = rx_cnt - 3'd1;
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt;
        if (wr_rise) begin
            tx_state_d = T_RECOVER;
            tx_cnt_d   = REC_INIT;
        end else if (tx_state == T_RECOVER) begin
            if (tx_cnt == '0)
                tx_state_d = T_IDLE;
            else
                tx_cnt_d = tx_cnt - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state   <= R_IDLE;
            tx_state   <= T_IDLE;
            rx_cnt     <= '0;
            tx_cnt     <= '0;
            rd_q       <= 1'b1;
            wr_q       <= 1'b1;
            data_q     <= '0;
            rx_wr_ptr  <= '0;
            rx_rd_ptr  <= '0;
            tx_wr_ptr  <= '0;
            tx_rd_ptr  <= '0;
            rx_count   <= '0;
            tx_count   <= '0;
            rxf_n      <= 1'b1;
            txe_n      <= 1'b1;
            host_full  <= 1'b0;
            host_avail <= 1'b0;
            err        <= '0;
        end else begin
            rx_state   <= rx_state_d;
            tx_state   <= tx_state_d;
            rx_cnt     <= rx_cnt_d;
            tx_cnt     <= tx_cnt_d;
            rd_q       <= rd_n;
            wr_q       <= wr_n;
            // data_q ends up holding the last bus value seen with wr_n low.
            if (!wr_n)
                data_q <= usb_data;
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            rx_count   <= rx_count_d;
            tx_count   <= tx_count_d;
            // Flags are computed from next state/occupancy so they stay registered
            // yet line up with the counts they describe.
            rxf_n      <= (rx_state_d == R_RECOVER) ||
                          ((rx_state_d == R_IDLE) && (rx_count_d == '0));
            txe_n      <= (tx_state_d == T_RECOVER) || (tx_count_d == FULL);
            host_full  <= (rx_count_d == FULL);
            host_avail <= (tx_count_d != '0);
            err        <= err | {~wr_n & drive, rd_fall & rxf_n};
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= host_din;
        if (tx_push) tx_mem[tx_wr_ptr] <= data_q;
    end

endmodule

// File: tb/tb_sp_usb_fifo_dev.sv
// tb_sp_usb_fifo_dev
//   Directed bench for sp_usb_fifo_dev. A queue-based model tracks both FIFOs
//   and derives the strobe/flag timing from edge timestamps. Every cycle the
//   DUT outputs are compared against that model, and literal expectations at
//   key points pin the model itself. The bus has a pull-up, so an undriven
//   usb_data reads as 8'hFF.
module tb_sp_usb_fifo_dev;

    localparam int unsigned DEPTH_LOG2 = 4;
    localparam int unsigned RD_LATENCY = 2;
    localparam int unsigned RECOVER    = 3;
    localparam int          DEPTH      = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rd_n = 1'b1, wr_n = 1'b1;
    logic [7:0] host_din = 8'h00;
    logic       host_write = 1'b0, host_read = 1'b0;
    logic       tb_oe = 1'b0;
    logic [7:0] tb_data = 8'h00;
    tri1  [7:0] usb_data;
    logic       rxf_n, txe_n, host_full, host_avail;
    logic [7:0] host_dout;
    logic [4:0] rx_count, tx_count;
    logic [1:0] err;

    assign usb_data = tb_oe ? tb_data : 8'hzz;

    sp_usb_fifo_dev #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .RD_LATENCY(RD_LATENCY),
        .RECOVER   (RECOVER)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .usb_data  (usb_data),
        .rxf_n     (rxf_n),
        .txe_n     (txe_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .host_din  (host_din),
        .host_write(host_write),
        .host_full (host_full),
        .host_dout (host_dout),
        .host_read (host_read),
        .host_avail(host_avail),
        .rx_count  (rx_count),
        .tx_count  (tx_count),
        .err       (err)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    logic       m_rxf_n = 1'b1, m_txe_n = 1'b1, m_drive = 1'b0, m_reading = 1'b0;
    logic       m_rd_q = 1'b1, m_wr_q = 1'b1;
    logic [1:0] m_err = 2'b00;
    logic [7:0] m_last = 8'h00;
    int         m_cyc = 0, m_fall = 0, m_rx_hold = 0, m_tx_hold = 0;

    function automatic logic [7:0] bus_model();
        if (m_drive) return rx_q[0];
        if (tb_oe)   return tb_data;
        return 8'hFF;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            rx_q.delete();
            tx_q.delete();
            m_rxf_n = 1'b1; m_txe_n = 1'b1; m_drive = 1'b0; m_reading = 1'b0;
            m_rd_q = 1'b1;  m_wr_q = 1'b1;  m_err = 2'b00;  m_last = 8'h00;
            m_cyc = 0; m_fall = 0; m_rx_hold = 0; m_tx_hold = 0;
        end else begin
            int   rx_n0, tx_n0;
            logic rdf, rdr, wrr;
            rx_n0 = rx_q.size();
            tx_n0 = tx_q.size();
            rdf = m_rd_q & ~rd_n;
            rdr = ~m_rd_q & rd_n;
            wrr = ~m_wr_q & wr_n;
            if (rdf && m_rxf_n)     m_err[0] = 1'b1;
            if (!wr_n && m_drive)   m_err[1] = 1'b1;
            if (!wr_n)              m_last = bus_model();
            if (rdr && m_reading) begin
                void'(rx_q.pop_front());
                m_reading = 1'b0;
                m_rx_hold = m_cyc + RECOVER;
            end
            if (rdf && !m_rxf_n) begin
                m_reading = 1'b1;
                m_fall    = m_cyc;
            end
            if (host_write && rx_n0 < DEPTH) rx_q.push_back(host_din);
            if (wrr) begin
                if (tx_n0 < DEPTH) tx_q.push_back(m_last);
                m_tx_hold = m_cyc + RECOVER;
            end
            if (host_read && tx_n0 > 0) void'(tx_q.pop_front());
            m_drive = m_reading && (m_cyc - m_fall >= int'(RD_LATENCY));
            m_rxf_n = m_reading ? 1'b0 : ((m_cyc < m_rx_hold) ? 1'b1 : (rx_q.size() == 0));
            m_txe_n = (m_cyc < m_tx_hold) ? 1'b1 : (tx_q.size() == DEPTH);
            m_rd_q  = rd_n;
            m_wr_q  = wr_n;
            m_cyc++;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(posedge clk);
        #2;
        chk("rxf_n",      rxf_n,      m_rxf_n);
        chk("txe_n",      txe_n,      m_txe_n);
        chk("usb_data",   usb_data,   bus_model());
        chk("rx_count",   rx_count,   rx_q.size());
        chk("tx_count",   tx_count,   tx_q.size());
        chk("host_full",  host_full,  rx_q.size() == DEPTH);
        chk("host_avail", host_avail, tx_q.size() != 0);
        chk("err",        err,        m_err);
        if (tx_q.size() != 0) chk("host_dout", host_dout, tx_q[0]);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic host_push(input logic [7:0] b);
        host_din = b; host_write = 1'b1;
        tick(1);
        host_write = 1'b0;
    endtask

    task automatic fpga_read(output logic [7:0] d);
        for (int i = 0; i < 64 && rxf_n; i++) tick(1);
        chk("rd_ready", rxf_n, 1'b0);
        rd_n = 1'b0;
        tick(RD_LATENCY + 1);
        d = usb_data;
        rd_n = 1'b1;
        tick(1 + RECOVER);
    endtask

    task automatic fpga_write(input logic [7:0] b, input int low);
        for (int i = 0; i < 64 && txe_n; i++) tick(1);
        chk("wr_ready", txe_n, 1'b0);
        tb_oe = 1'b1; tb_data = b; wr_n = 1'b0;
        tick(low);
        wr_n = 1'b1;
        tick(1);
        tb_oe = 1'b0;
        tick(RECOVER);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        logic [7:0] d;

        // reset state
        tick(2);
        chk("rst_rxf_n", rxf_n, 1'b1);
        chk("rst_txe_n", txe_n, 1'b1);
        chk("rst_bus",   usb_data, 8'hFF);
        chk("rst_rxcnt", rx_count, 0);
        chk("rst_txcnt", tx_count, 0);
        chk("rst_err",   err, 2'b00);
        chk("rst_full",  host_full, 1'b0);
        chk("rst_avail", host_avail, 1'b0);
        rst = 1'b1;
        tick(2);

        // 1: single RX byte, latency and recovery
        host_push(8'h5A);
        chk("t1_rxf_low", rxf_n, 1'b0);
        chk("t1_rxcnt",   rx_count, 1);
        rd_n = 1'b0;
        tick(2);
        chk("t1_not_yet", usb_data, 8'hFF);
        tick(1);
        chk("t1_drive",   usb_data, 8'h5A);
        rd_n = 1'b1;
        tick(1);
        chk("t1_release", usb_data, 8'hFF);
        chk("t1_rxf_hi",  rxf_n, 1'b1);
        chk("t1_rxcnt0",  rx_count, 0);
        host_din = 8'h66; host_write = 1'b1;
        tick(1);
        host_write = 1'b0;
        chk("t1_hold1",   rxf_n, 1'b1);
        tick(1);
        chk("t1_hold2",   rxf_n, 1'b1);
        tick(1);
        chk("t1_hold_end", rxf_n, 1'b0);
        fpga_read(d);
        chk("t1_read66",  d, 8'h66);

        // 2: single TX byte
        tb_oe = 1'b1; tb_data = 8'hC3; wr_n = 1'b0;
        tick(3);
        wr_n = 1'b1;
        tick(1);
        tb_oe = 1'b0;
        chk("t2_avail", host_avail, 1'b1);
        chk("t2_dout",  host_dout, 8'hC3);
        chk("t2_txe_hi", txe_n, 1'b1);
        tick(2);
        chk("t2_txe_hold", txe_n, 1'b1);
        tick(1);
        chk("t2_txe_low", txe_n, 1'b0);
        host_read = 1'b1;
        tick(1);
        host_read = 1'b0;
        chk("t2_txcnt0", tx_count, 0);

        // 3: RX fill, overflow ignored, ordered drain, pointer wrap
        for (int i = 0; i < 16; i++) host_push(8'(i));
        chk("t3_full",  host_full, 1'b1);
        chk("t3_cnt16", rx_count, 16);
        host_push(8'hAA);
        chk("t3_17th_ignored", rx_count, 16);
        for (int i = 0; i < 16; i++) begin
            fpga_read(d);
            chk("t3_order", d, i);
        end
        chk("t3_empty", rx_count, 0);
        for (int i = 0; i < 8; i++) host_push(8'(8'h20 + i));
        for (int i = 0; i < 8; i++) begin
            fpga_read(d);
            chk("t3_wrap", d, 8'h20 + i);
        end

        // 4: TX fill, txe_n on full, pop releases, push+pop same clock
        for (int i = 0; i < 16; i++) fpga_write(8'(8'h80 + i), 1);
        chk("t4_cnt16",   tx_count, 16);
        chk("t4_txe_full", txe_n, 1'b1);
        host_read = 1'b1;
        tick(1);
        host_read = 1'b0;
        chk("t4_txe_after_pop", txe_n, 1'b0);
        chk("t4_cnt15", tx_count, 15);
        tb_oe = 1'b1; tb_data = 8'h77; wr_n = 1'b0;
        tick(1);
        wr_n = 1'b1; host_read = 1'b1;
        tick(1);
        host_read = 1'b0; tb_oe = 1'b0;
        chk("t4_push_pop", tx_count, 15);
        chk("t4_head",     host_dout, 8'h82);
        tick(RECOVER);
        for (int i = 2; i < 16; i++) begin
            chk("t4_drain", host_dout, 8'h80 + i);
            host_read = 1'b1;
            tick(1);
            host_read = 1'b0;
        end
        chk("t4_last", host_dout, 8'h77);
        host_read = 1'b1;
        tick(1);
        host_read = 1'b0;
        chk("t4_empty", tx_count, 0);

        // 5: error flags
        rd_n = 1'b0;
        tick(1);
        rd_n = 1'b1;
        tick(1);
        chk("t5_err0",   err, 2'b01);
        chk("t5_bus_z",  usb_data, 8'hFF);
        tick(RECOVER);
        host_push(8'h3C);
        rd_n = 1'b0;
        tick(RD_LATENCY + 1);
        chk("t5_drive", usb_data, 8'h3C);
        wr_n = 1'b0;
        tick(1);
        chk("t5_err1",  err, 2'b11);
        chk("t5_contention_visible", usb_data, 8'h3C);
        wr_n = 1'b1;
        tick(1);
        rd_n = 1'b1;
        tick(1 + RECOVER);
        chk("t5_txcnt", tx_count, 1);
        chk("t5_txbyte", host_dout, 8'h3C);
        host_read = 1'b1;
        tick(1);
        host_read = 1'b0;

        // 6: async reset during a driven read
        fpga_write(8'h5E, 2);
        host_push(8'h11);
        rd_n = 1'b0;
        tick(RD_LATENCY + 1);
        chk("t6_drive", usb_data, 8'h11);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_bus_z",  usb_data, 8'hFF);
        chk("t6_rxf_n",  rxf_n, 1'b1);
        chk("t6_txe_n",  txe_n, 1'b1);
        chk("t6_rxcnt",  rx_count, 0);
        chk("t6_txcnt",  tx_count, 0);
        chk("t6_err",    err, 2'b00);
        rd_n = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(3);
        chk("t6_post_rxf", rxf_n, 1'b1);
        chk("t6_post_txe", txe_n, 1'b0);
        chk("t6_post_cnt", rx_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
